// File: rtl/alu_wb_frontend.sv
// Wishbone-classic register front end for a four-lane ALU: operand/op registers, START-driven
// latency sequencer and result/flag capture. Optional level IRQ on done via ALU_FRONTEND_IRQ_EN.
//   state | meaning
//   IDLE  | no operation in flight, done clear
//   EXEC  | operands launched, latency counter running (busy)
//   DONE  | result and flags captured, done held until cleared or restarted
module alu_wb_frontend #(
  parameter int unsigned LATENCY = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [3:0]  wbs_sel_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic [63:0] alu_a,
  output logic [63:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [63:0] alu_result,
  input  logic [3:0]  alu_exception,
  input  logic [3:0]  alu_overflow,
  input  logic [3:0]  alu_underflow,
  output logic        irq
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] a_lo_q, a_hi_q, b_lo_q, b_hi_q;
  logic [3:0]  op_q;
  logic        start_q;
  logic        done_q;
  logic [3:0]  cnt_q;
  logic [63:0] res_q;
  logic [3:0]  exc_q, ovf_q, unf_q;
  logic [31:0] rdata;
  logic        req, wr, rd, busy, start_go, capture, done_clr;
  logic [2:0]  idx;
  logic        unused_adr;

  assign unused_adr = ^{wbs_adr_i[31:5], wbs_adr_i[1:0]};

  assign idx      = wbs_adr_i[4:2];
  assign req      = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
  assign wr       = req & wbs_we_i;
  assign rd       = req & ~wbs_we_i;
  assign busy     = (state_q == EXEC);
  assign start_go = start_q & ~busy;
  assign capture  = busy & (cnt_q == 4'd1);
  assign done_clr = wr & (idx == 3'd5) & wbs_sel_i[0] & wbs_dat_i[1];

  assign alu_a  = {a_hi_q, a_lo_q};
  assign alu_b  = {b_hi_q, b_lo_q};
  assign alu_op = op_q;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din,
                                        input logic [3:0] sel);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sel[i] ? din[8*i +: 8] : old[8*i +: 8];
    return r;
  endfunction

  always_comb begin
    rdata = '0;
    case (idx)
      3'd0: rdata = a_lo_q;
      3'd1: rdata = a_hi_q;
      3'd2: rdata = b_lo_q;
      3'd3: rdata = b_hi_q;
      3'd4: rdata = {28'd0, op_q};
      3'd5: rdata = {16'd0, unf_q, ovf_q, exc_q, 2'd0, done_q, busy};
      3'd6: rdata = res_q[31:0];
      3'd7: rdata = res_q[63:32];
      default: rdata = '0;
    endcase
  end

  // Register writes land in the request cycle; ack and read data follow one cycle later.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      a_lo_q    <= '0;
      a_hi_q    <= '0;
      b_lo_q    <= '0;
      b_hi_q    <= '0;
      op_q      <= '0;
      start_q   <= 1'b0;
    end else begin
      wbs_ack_o <= req;
      wbs_dat_o <= rd ? rdata : '0;
      start_q   <= 1'b0;
      if (wr && !busy) begin
        case (idx)
          3'd0: a_lo_q <= merge(a_lo_q, wbs_dat_i, wbs_sel_i);
          3'd1: a_hi_q <= merge(a_hi_q, wbs_dat_i, wbs_sel_i);
          3'd2: b_lo_q <= merge(b_lo_q, wbs_dat_i, wbs_sel_i);
          3'd3: b_hi_q <= merge(b_hi_q, wbs_dat_i, wbs_sel_i);
          3'd4: begin
            if (wbs_sel_i[0]) op_q <= wbs_dat_i[3:0];
            if (wbs_sel_i[1] && wbs_dat_i[8]) start_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) state_q <= IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_q) state_d = EXEC;
      EXEC: if (capture) state_d = DONE;
      DONE: begin
        if (start_q)      state_d = EXEC;
        else if (!done_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
      res_q  <= '0;
      exc_q  <= '0;
      ovf_q  <= '0;
      unf_q  <= '0;
    end else begin
      if (start_go)                 cnt_q <= 4'(LATENCY);
      else if (busy && cnt_q != '0) cnt_q <= cnt_q - 4'd1;

      if (capture) begin
        res_q  <= alu_result;
        exc_q  <= alu_exception;
        ovf_q  <= alu_overflow;
        unf_q  <= alu_underflow;
        done_q <= 1'b1;
      end else if (start_go || done_clr) begin
        done_q <= 1'b0;
      end
    end
  end

`ifdef ALU_FRONTEND_IRQ_EN
  assign irq = done_q;
`else
  assign irq = 1'b0;
`endif

endmodule
